// File: rtl/operand_fetch.sv
// Operand fetch stage: serially reads rs1/rs2 through one regfile port.
// Optional OPERAND_BYPASS_EN forwards and tracks writebacks into operands.
module operand_fetch #(
  parameter int size     = 5,
  parameter int width    = 32,
  parameter int opw      = 8,
  parameter bit zero_reg = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN_enq,
  output logic             RDY_enq,
  input  logic [opw-1:0]   enq_op,
  input  logic [size-1:0]  enq_rs1,
  input  logic [size-1:0]  enq_rs2,
  input  logic [size-1:0]  enq_rd,
  output logic [size-1:0]  rf_sub_x,
  input  logic [width-1:0] rf_sub,
  input  logic             EN_wb,
  input  logic [size-1:0]  wb_x,
  input  logic [width-1:0] wb_y,
  output logic             RDY_deq,
  input  logic             EN_deq,
  output logic [opw-1:0]   deq_op,
  output logic [width-1:0] deq_a,
  output logic [width-1:0] deq_b,
  output logic [size-1:0]  deq_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    FULL = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [size-1:0]   rs1_q, rs1_d;
  logic [size-1:0]   rs2_q, rs2_d;
  logic [size-1:0]   rd_q, rd_d;
  logic [opw-1:0]    op_q, op_d;
  logic [width-1:0]  a_q, a_d;
  logic [width-1:0]  b_q, b_d;
  logic [size-1:0]   sub_x_q, sub_x_d;
  logic              rdy_enq_q, rdy_enq_d;
  logic              rdy_deq_q, rdy_deq_d;
  logic [width-1:0]  rd_val;

  function automatic logic is_zero(input logic [size-1:0] x);
    return zero_reg && (x == '0);
  endfunction

`ifdef OPERAND_BYPASS_EN
  logic wb_ok;
  assign wb_ok = EN_wb && !is_zero(wb_x);

  always_comb begin
    rd_val = rf_sub;
    if (is_zero(sub_x_q))
      rd_val = '0;
    else if (wb_ok && (wb_x == sub_x_q))
      rd_val = wb_y;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{EN_wb, wb_x, wb_y};

  always_comb begin
    rd_val = rf_sub;
    if (is_zero(sub_x_q))
      rd_val = '0;
  end
`endif

  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      IDLE: begin
        if (EN_enq) begin
          state_d = RD1;
          rs1_d   = enq_rs1;
          rs2_d   = enq_rs2;
          rd_d    = enq_rd;
          op_d    = enq_op;
        end
      end
      RD1: begin
        a_d     = rd_val;
        state_d = RD2;
      end
      RD2: begin
        b_d     = rd_val;
        state_d = FULL;
`ifdef OPERAND_BYPASS_EN
        if (wb_ok && (wb_x == rs1_q))
          a_d = wb_y;
`endif
      end
      FULL: begin
        if (EN_deq)
          state_d = IDLE;
`ifdef OPERAND_BYPASS_EN
        // Dequeue sees current regs; the update lands at this edge.
        if (wb_ok && (wb_x == rs1_q))
          a_d = wb_y;
        if (wb_ok && (wb_x == rs2_q))
          b_d = wb_y;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sub_x_d   = '0;
    rdy_enq_d = (state_d == IDLE);
    rdy_deq_d = (state_d == FULL);
    if (state_d == RD1)
      sub_x_d = (state_q == IDLE) ? enq_rs1 : rs1_q;
    else if (state_d == RD2)
      sub_x_d = rs2_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sub_x_q   <= '0;
      rdy_enq_q <= 1'b1;
      rdy_deq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sub_x_q   <= sub_x_d;
      rdy_enq_q <= rdy_enq_d;
      rdy_deq_q <= rdy_deq_d;
    end
  end

  assign RDY_enq  = rdy_enq_q;
  assign RDY_deq  = rdy_deq_q;
  assign rf_sub_x = sub_x_q;
  assign deq_op   = op_q;
  assign deq_a    = a_q;
  assign deq_b    = b_q;
  assign deq_rd   = rd_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file.
// Expectations follow OPERAND_BYPASS_EN when it is defined.
module tb_operand_fetch;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN_enq;
  logic        RDY_enq;
  logic [7:0]  enq_op;
  logic [4:0]  enq_rs1;
  logic [4:0]  enq_rs2;
  logic [4:0]  enq_rd;
  logic [4:0]  rf_sub_x;
  logic [31:0] rf_sub;
  logic        EN_wb;
  logic [4:0]  wb_x;
  logic [31:0] wb_y;
  logic        RDY_deq;
  logic        EN_deq;
  logic [7:0]  deq_op;
  logic [31:0] deq_a;
  logic [31:0] deq_b;
  logic [4:0]  deq_rd;

  int checks = 0;
  int failures = 0;
  logic [31:0] rf [32];

  operand_fetch dut (
    .CLK(CLK), .RST(RST),
    .EN_enq(EN_enq), .RDY_enq(RDY_enq),
    .enq_op(enq_op), .enq_rs1(enq_rs1),
    .enq_rs2(enq_rs2), .enq_rd(enq_rd),
    .rf_sub_x(rf_sub_x), .rf_sub(rf_sub),
    .EN_wb(EN_wb), .wb_x(wb_x), .wb_y(wb_y),
    .RDY_deq(RDY_deq), .EN_deq(EN_deq),
    .deq_op(deq_op), .deq_a(deq_a),
    .deq_b(deq_b), .deq_rd(deq_rd)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK)
    if (EN_wb) rf[wb_x] <= wb_y;

  assign rf_sub = rf[rf_sub_x];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] x,
                          input logic [31:0] y);
    EN_wb = 1'b1; wb_x = x; wb_y = y;
    tick();
    EN_wb = 1'b0;
  endtask

  task automatic enq(input logic [7:0] op, input logic [4:0] r1,
                     input logic [4:0] r2, input logic [4:0] rd);
    EN_enq = 1'b1; enq_op = op;
    enq_rs1 = r1; enq_rs2 = r2; enq_rd = rd;
    tick();
    EN_enq = 1'b0;
  endtask

  task automatic deq();
    EN_deq = 1'b1;
    tick();
    EN_deq = 1'b0;
  endtask

  logic [31:0] exp_a;
  logic [31:0] snap_a, snap_b;

  initial begin
    RST = 1'b1; EN_enq = 1'b0; EN_deq = 1'b0; EN_wb = 1'b0;
    enq_op = '0; enq_rs1 = '0; enq_rs2 = '0; enq_rd = '0;
    wb_x = '0; wb_y = '0;
    #12;
    chk("rst_rdy_enq", 32'(RDY_enq), 32'd1);
    chk("rst_rdy_deq", 32'(RDY_deq), 32'd0);
    chk("rst_deq_a", deq_a, 32'd0);
    chk("rst_sub_x", 32'(rf_sub_x), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    tick();

    wb_write(5'd3, 32'h11);
    wb_write(5'd7, 32'h22);
    wb_write(5'd0, 32'hDEAD);
    wb_write(5'd4, 32'h1);
    wb_write(5'd6, 32'h55);

    // basic fetch, latency 3
    enq(8'h5A, 5'd3, 5'd7, 5'd9);
    chk("bas_sub_x1", 32'(rf_sub_x), 32'd3);
    chk("bas_rdy_enq", 32'(RDY_enq), 32'd0);
    chk("bas_rdy_deq1", 32'(RDY_deq), 32'd0);
    tick();
    chk("bas_sub_x2", 32'(rf_sub_x), 32'd7);
    chk("bas_rdy_deq2", 32'(RDY_deq), 32'd0);
    tick();
    chk("bas_rdy_deq3", 32'(RDY_deq), 32'd1);
    chk("bas_a", deq_a, 32'h11);
    chk("bas_b", deq_b, 32'h22);
    chk("bas_rd", 32'(deq_rd), 32'd9);
    chk("bas_op", 32'(deq_op), 32'h5A);
    chk("bas_sub_x0", 32'(rf_sub_x), 32'd0);

    // backpressure with ignored enqueue attempts
    for (int i = 0; i < 10; i++) begin
      EN_enq = (i == 4); enq_op = 8'hFF;
      enq_rs1 = 5'd7; enq_rs2 = 5'd3; enq_rd = 5'd1;
      tick();
    end
    EN_enq = 1'b0;
    chk("bp_rdy_enq", 32'(RDY_enq), 32'd0);
    chk("bp_rdy_deq", 32'(RDY_deq), 32'd1);
    chk("bp_a", deq_a, 32'h11);
    chk("bp_b", deq_b, 32'h22);
    chk("bp_op", 32'(deq_op), 32'h5A);
    chk("bp_rd", 32'(deq_rd), 32'd9);
    deq();
    chk("bp_rdy_enq2", 32'(RDY_enq), 32'd1);
    chk("bp_rdy_deq2", 32'(RDY_deq), 32'd0);
    // stray deq while idle is ignored
    deq();
    chk("idle_deq", 32'(RDY_enq), 32'd1);

    // zero register
    enq(8'h01, 5'd0, 5'd0, 5'd2);
    tick(); tick();
    chk("zr_rdy", 32'(RDY_deq), 32'd1);
    chk("zr_a", deq_a, 32'd0);
    chk("zr_b", deq_b, 32'd0);
    deq();

    // writeback during RD1 of rs1
    enq(8'h02, 5'd4, 5'd3, 5'd5);
    EN_wb = 1'b1; wb_x = 5'd4; wb_y = 32'h9;
    tick();
    EN_wb = 1'b0;
    tick();
`ifdef OPERAND_BYPASS_EN
    exp_a = 32'h9;
`else
    exp_a = 32'h1;
`endif
    chk("byp_a", deq_a, exp_a);
    chk("byp_b", deq_b, 32'h11);
    deq();

    // late writebacks while FULL
    enq(8'h03, 5'd3, 5'd6, 5'd8);
    tick(); tick();
    chk("late_b0", deq_b, 32'h55);
    wb_write(5'd3, 32'h33);
`ifdef OPERAND_BYPASS_EN
    exp_a = 32'h33;
`else
    exp_a = 32'h11;
`endif
    chk("late_a", deq_a, exp_a);
    EN_deq = 1'b1; EN_wb = 1'b1;
    wb_x = 5'd6; wb_y = 32'h77;
    #1;
    snap_a = deq_a; snap_b = deq_b;
    tick();
    EN_deq = 1'b0; EN_wb = 1'b0;
    chk("late_deq_b", snap_b, 32'h55);
    chk("late_deq_a", snap_a, exp_a);
    chk("late_idle", 32'(RDY_enq), 32'd1);
    enq(8'h04, 5'd6, 5'd6, 5'd6);
    tick(); tick();
    chk("same_a", deq_a, 32'h77);
    chk("same_b", deq_b, 32'h77);
    deq();

    // async reset mid-RD2
    enq(8'hC3, 5'd3, 5'd7, 5'd4);
    tick();
    #2;
    RST = 1'b1;
    #1;
    chk("arst_rdy_enq", 32'(RDY_enq), 32'd1);
    chk("arst_rdy_deq", 32'(RDY_deq), 32'd0);
    chk("arst_a", deq_a, 32'd0);
    chk("arst_b", deq_b, 32'd0);
    chk("arst_op", 32'(deq_op), 32'd0);
    chk("arst_rd", 32'(deq_rd), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    tick(); tick(); tick();
    chk("arst_hold", 32'(RDY_deq), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
